// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the nibble mux serializer.
package nibble_ser_pkg;

  localparam int NUM_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : nibble_ser_pkg

// File: rtl/nibble_mux_serializer.sv
// Sequencer around an external bit-select mux: walks selection over a loaded word,
// streams mux_y serially and rebuilds/checks the word. Optional parity bit: NIBBLE_SER_PARITY_EN.
module nibble_mux_serializer
  import nibble_ser_pkg::*;
#(
  parameter int NUM_W     = NUM_W_DEF,
  parameter bit MSB_FIRST = 1'b0,
  localparam int SEL_W    = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_data,
  output logic [NUM_W-1:0] number,
  output logic [SEL_W-1:0] selection,
  input  logic             mux_y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic [NUM_W-1:0] word_out,
  output logic             word_valid,
  output logic             mismatch
);

  localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(NUM_W - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(NUM_W - 1);

  state_e           r_state;
  state_e           w_next;
  logic [NUM_W-1:0] r_number;
  logic [SEL_W-1:0] r_sel;
  logic [NUM_W-1:0] r_word;
  logic             w_at_last;

  assign w_at_last = (r_sel == LAST_IDX);

  // NOTE: every output and w_next gets a default before the case, so no path
  // through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_last   = 1'b0;
    word_valid = 1'b0;
    mismatch   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = mux_y;
`ifdef NIBBLE_SER_PARITY_EN
        ser_last  = 1'b0;
        if (ser_ready && w_at_last) w_next = PAR;
`else
        ser_last  = w_at_last;
        if (ser_ready && w_at_last) w_next = DONE;
`endif
      end
      PAR: begin
`ifdef NIBBLE_SER_PARITY_EN
        ser_valid = 1'b1;
        ser_bit   = ^r_word;
        ser_last  = 1'b1;
        if (ser_ready) w_next = DONE;
`else
        w_next = IDLE;
`endif
      end
      DONE: begin
        word_valid = 1'b1;
        mismatch   = (r_word != r_number);
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_number <= '0;
      r_sel    <= '0;
      r_word   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_number <= in_data;
            r_sel    <= FIRST_IDX;
            r_word   <= '0;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            r_word[r_sel] <= mux_y;
            // Selection stops on the last index rather than wrapping.
            if (!w_at_last) r_sel <= MSB_FIRST ? r_sel - 1'b1 : r_sel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign number    = r_number;
  assign selection = r_sel;
  assign word_out  = r_word;

endmodule : nibble_mux_serializer
